// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot or auto-reload expiry pulse.
// Optional tick prescaler enabled by defining COUNTDOWN_PRESCALE_EN.
module countdown_timer #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned MAX_COUNT = 999,
  parameter int unsigned PRESCALE  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  // Elaboration-time parameter sanity checks
  if ((MAX_COUNT >> WIDTH) != 0) begin : g_bad_max_count
    $error("countdown_timer: MAX_COUNT does not fit in WIDTH bits");
  end
  if (PRESCALE == 0) begin : g_bad_prescale_zero
    $error("countdown_timer: PRESCALE must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_d;
  logic             tick;

`ifdef COUNTDOWN_PRESCALE_EN
  localparam int unsigned PRESC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("countdown_timer: PRESCALE must be 2 or more");
  end

  logic [PRESC_W-1:0] presc_q, presc_d;

  assign tick = (presc_q == PRESC_LAST);
`else
  assign tick = 1'b1;
`endif

  // Next-state and datapath: load beats pause beats start
  always_comb begin
    state_d   = state_q;
    count_d   = count;
    reload_d  = reload_q;
    expired_d = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
    presc_d   = presc_q;
`endif

    if (load) begin
      count_d  = (load_value > MAX_C) ? MAX_C : load_value;
      reload_d = (load_value > MAX_C) ? MAX_C : load_value;
      state_d  = IDLE;
`ifdef COUNTDOWN_PRESCALE_EN
      presc_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (count != '0)) begin
            state_d = RUN;
`ifdef COUNTDOWN_PRESCALE_EN
            presc_d = '0;
`endif
          end
        end
        HOLD: begin
          // Resume keeps the partial prescaler phase
          if (start) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else begin
`ifdef COUNTDOWN_PRESCALE_EN
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
`endif
            if (tick) begin
              if (count > ONE_C) begin
                count_d = count - ONE_C;
              end else begin
                expired_d = 1'b1;
                if (auto_reload && (reload_q != '0)) begin
                  count_d = reload_q;
                end else begin
                  count_d = '0;
                  state_d = IDLE;
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count    <= '0;
      reload_q <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
      presc_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      reload_q <= reload_d;
      running  <= (state_d == RUN);
      expired  <= expired_d;
`ifdef COUNTDOWN_PRESCALE_EN
      presc_q  <= presc_d;
`endif
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Prescaler scenario runs only when COUNTDOWN_PRESCALE_EN is defined.
module tb_countdown_timer;

  localparam int unsigned WIDTH = 10;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expired;

  int checks;
  int errors;

  countdown_timer #(
    .WIDTH(WIDTH),
    .MAX_COUNT(999),
    .PRESCALE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_value(load_value),
    .start(start),
    .pause(pause),
    .auto_reload(auto_reload),
    .count(count),
    .running(running),
    .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++; if (count !== 10'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b expected 0", running); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired got %b expected 0", expired); end
    rst = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [WIDTH-1:0] exp_count;
    load = 1'b1; load_value = 10'd5;
    cycle();
    load = 1'b0;
    checks++; if (count !== 10'd5) begin errors++; $display("FAIL oneshot_load got %0d expected 5", count); end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL oneshot_start_running got %b expected 1", running); end
    checks++; if (count !== 10'd5) begin errors++; $display("FAIL oneshot_start_count got %0d expected 5", count); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      exp_count = WIDTH'(4 - i);
      checks++; if (count !== exp_count) begin errors++; $display("FAIL oneshot_count[%0d] got %0d expected %0d", i, count, exp_count); end
      checks++; if (expired !== (i == 4)) begin errors++; $display("FAIL oneshot_expired[%0d] got %b expected %b", i, expired, (i == 4)); end
      checks++; if (running !== (i != 4)) begin errors++; $display("FAIL oneshot_running[%0d] got %b expected %b", i, running, (i != 4)); end
    end
    cycle();
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL oneshot_after_expired got %b expected 0", expired); end
    checks++; if (running !== 1'b0 || count !== 10'd0) begin errors++; $display("FAIL oneshot_after_state got run=%b count=%0d expected run=0 count=0", running, count); end
  endtask

  task automatic test_auto_reload();
    logic [WIDTH-1:0] seq [7];
    seq = '{10'd2, 10'd1, 10'd3, 10'd2, 10'd1, 10'd3, 10'd2};
    load = 1'b1; load_value = 10'd3; auto_reload = 1'b1;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      checks++; if (count !== seq[i]) begin errors++; $display("FAIL reload_count[%0d] got %0d expected %0d", i, count, seq[i]); end
      checks++; if (expired !== (seq[i] == 10'd3)) begin errors++; $display("FAIL reload_expired[%0d] got %b expected %b", i, expired, (seq[i] == 10'd3)); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL reload_running[%0d] got %b expected 1", i, running); end
    end
    // Clearing auto_reload mid-run makes the next expiry terminal
    auto_reload = 1'b0;
    cycle();
    checks++; if (count !== 10'd1) begin errors++; $display("FAIL reload_off_count got %0d expected 1", count); end
    cycle();
    checks++; if (count !== 10'd0 || expired !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL reload_off_expire got count=%0d exp=%b run=%b expected 0 1 0", count, expired, running); end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_value = 10'd1023;
    cycle();
    checks++; if (count !== 10'd999) begin errors++; $display("FAIL saturate_count got %0d expected 999", count); end
    load_value = 10'd0;
    cycle();
    load = 1'b0;
    checks++; if (count !== 10'd0) begin errors++; $display("FAIL load_zero_count got %0d expected 0", count); end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL start_zero got run=%b exp=%b expected 0 0", running, expired); end
    cycle();
    checks++; if (running !== 1'b0 || expired !== 1'b0 || count !== 10'd0) begin errors++; $display("FAIL start_zero_after got run=%b exp=%b count=%0d expected 0 0 0", running, expired, count); end
  endtask

  task automatic test_pause();
    logic [WIDTH-1:0] exp_count;
    load = 1'b1; load_value = 10'd10;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    checks++; if (count !== 10'd6) begin errors++; $display("FAIL pre_pause_count got %0d expected 6", count); end
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      checks++; if (count !== 10'd6 || running !== 1'b0) begin errors++; $display("FAIL pause_hold[%0d] got count=%0d run=%b expected 6 0", i, count, running); end
    end
    pause = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if (count !== 10'd6 || running !== 1'b1) begin errors++; $display("FAIL resume got count=%0d run=%b expected 6 1", count, running); end
    for (int i = 0; i < 6; i++) begin
      cycle();
      exp_count = WIDTH'(5 - i);
      checks++; if (count !== exp_count) begin errors++; $display("FAIL resume_count[%0d] got %0d expected %0d", i, count, exp_count); end
      checks++; if (expired !== (i == 5)) begin errors++; $display("FAIL resume_expired[%0d] got %b expected %b", i, expired, (i == 5)); end
    end
  endtask

  task automatic test_priority_and_reset();
    load = 1'b1; load_value = 10'd7;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    checks++; if (count !== 10'd5) begin errors++; $display("FAIL prio_setup got %0d expected 5", count); end
    load = 1'b1; pause = 1'b1; start = 1'b1; load_value = 10'd8;
    cycle();
    load = 1'b0; pause = 1'b0; start = 1'b0;
    checks++; if (count !== 10'd8 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL prio_load got count=%0d run=%b exp=%b expected 8 0 0", count, running, expired); end
    cycle();
    checks++; if (count !== 10'd8 || running !== 1'b0) begin errors++; $display("FAIL prio_idle got count=%0d run=%b expected 8 0", count, running); end
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    checks++; if (count !== 10'd7 || running !== 1'b1) begin errors++; $display("FAIL rst_setup got count=%0d run=%b expected 7 1", count, running); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (count !== 10'd0 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL rst_midrun got count=%0d run=%b exp=%b expected 0 0 0", count, running, expired); end
    // Reset on the expiring edge must swallow the pulse
    load = 1'b1; load_value = 10'd1;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (expired !== 1'b0 || count !== 10'd0) begin errors++; $display("FAIL rst_on_expiry got exp=%b count=%0d expected 0 0", expired, count); end
  endtask

`ifdef COUNTDOWN_PRESCALE_EN
  task automatic test_prescale();
    logic [WIDTH-1:0] exp_count;
    load = 1'b1; load_value = 10'd3;
    cycle();
    load = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cycle();
      exp_count = WIDTH'(3 - n / 4);
      checks++; if (count !== exp_count) begin errors++; $display("FAIL presc_count[%0d] got %0d expected %0d", n, count, exp_count); end
      checks++; if (expired !== (n == 12)) begin errors++; $display("FAIL presc_expired[%0d] got %b expected %b", n, expired, (n == 12)); end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    load = 1'b0;
    load_value = '0;
    start = 1'b0;
    pause = 1'b0;
    auto_reload = 1'b0;
    test_reset();
`ifdef COUNTDOWN_PRESCALE_EN
    test_prescale();
`else
    test_oneshot();
    test_auto_reload();
    test_saturate();
    test_pause();
    test_priority_and_reset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer, the decrementing counterpart to the free-running mod-1000 up-counter. It loads a start value in the range 0..MAX_COUNT and decrements once per tick while running. It pulses `expired` when the count reaches zero, and can optionally auto-reload for periodic timeouts. It sits beside the up-counter in the timing subsystem and provides timeouts and periodic events to control logic.

## Interface
- WIDTH, 10: count/load width in bits.
- MAX_COUNT, 999: largest legal count value; loads above it saturate.
- PRESCALE, 1000: ticks are one per PRESCALE clocks. Used only when COUNTDOWN_PRESCALE_EN is defined; legal range is 2 or more.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  captures load_value; highest priority of all controls.
- load_value  in  WIDTH  new start/reload value.
- start  in  1  begin, or resume, counting.
- pause  in  1  suspend counting.
- auto_reload  in  1  on expiry, reload and keep running instead of stopping.
- count  out  WIDTH  current count, registered.
- running  out  1  high in state RUN, registered.
- expired  out  1  single-cycle pulse on expiry, registered.

## Operation
- State machine states:
  - IDLE: stopped.
  - RUN: decrementing on each tick.
  - HOLD: paused, count frozen.
- Internal reload_reg (WIDTH bits) holds the last loaded value.
- Reset values:
  - count = 0, reload_reg = 0, state = IDLE.
  - running = 0, expired = 0.
  - Prescaler = 0.
- Control priority per cycle is load, then pause, then start.
- load in any state:
  - reload_reg and count both get min(load_value, MAX_COUNT).
  - State goes to IDLE.
  - Prescaler clears.
  - A decrement or expiry in the same cycle is discarded.
- pause:
  - In RUN: go to HOLD.
  - In other states: ignored.
- start:
  - In IDLE with count ≠ 0: go to RUN and clear the prescaler.
  - In IDLE with count = 0: ignored and stays IDLE.
  - In HOLD: go to RUN; the prescaler keeps its value.
  - In RUN: no effect.
- Tick in RUN:
  - count > 1: count decrements by 1.
  - count = 1, auto_reload = 1, reload_reg ≠ 0: count gets reload_reg, stay in RUN, expired = 1 next cycle.
  - count = 1, otherwise: count gets 0, go to IDLE, expired = 1 next cycle.
- Decrement never underflows; count = 0 is unreachable in RUN.
- auto_reload is sampled on the expiring tick only, so changing it mid-run is legal.
- expired is 0 in every cycle other than the one following an expiring tick.

## Timing
- Without the prescaler:
  - Start sampled at edge k: running = 1 after edge k.
  - First decrement is at edge k+1.
  - For loaded value L, the expiring tick is at edge k+L.
  - count = 0 (or the reload value) and expired = 1 are both visible after edge k+L.
- Auto-reload period is exactly reload_reg ticks between expired pulses.
- Pause at edge p: the count after edge p equals the count before it; no decrement occurs on the pausing edge.
- Output latency: all outputs are registered, with zero combinational paths from input to output.
- Reset mid-run returns to the reset values at the next edge; no expired pulse is emitted.

## Configuration
- Macro COUNTDOWN_PRESCALE_EN:
  - Defined: a $clog2(PRESCALE)-bit prescaler counts 0..PRESCALE-1 while in RUN. A tick occurs on the cycle the prescaler equals PRESCALE-1, after which it wraps to 0. The prescaler holds in HOLD and IDLE. With L loaded, expiry occurs L×PRESCALE cycles after start.
  - Undefined: no prescaler logic; every clock in RUN is a tick. The PRESCALE parameter is ignored.

## Test plan
- Reset, load 5, start (no prescaler) -> count 4,3,2,1,0 on consecutive cycles; expired high for exactly one cycle together with count = 0; running = 0 afterwards.
- Load 3, auto_reload = 1, start -> count follows 2,1,3,2,1,3…; expired pulses every 3 cycles; running stays 1.
- Load 1023 -> count = 999. Then load 0 and start -> remains IDLE, no pulse.
- Load 10, start, pause after 4 cycles for 7 cycles, then start -> count holds at 6 during the pause; expired occurs 6 cycles after resume.
- load, pause and start asserted together while running at count 5 with load_value 8 -> count = 8, IDLE, no expired; rst asserted mid-run -> all outputs 0 next cycle.
- With COUNTDOWN_PRESCALE_EN defined and PRESCALE = 4, load 3, start -> count changes every 4 cycles; expired occurs 12 cycles after start.
